// File: rtl/pipelined_addsub.sv
// Pipelined adder/subtractor: each stage resolves one DIGIT-bit slice and ripples its carry onward.
// Optional: define PIPE_ADDSUB_OVF_EN to capture the MSB carry and report signed overflow on ovf.
module pipelined_addsub #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    output logic [WIDTH-1:0] s,
    output logic             c,
    output logic             ovf
);
    localparam int NSTAGES = (WIDTH + DIGIT - 1) / DIGIT;

    logic [WIDTH-1:0] bEff;
    logic             cEff;
    logic [WIDTH-1:0] stageSum_d   [NSTAGES];
    logic             stageCarry_d [NSTAGES];
    logic             stageValid_d [NSTAGES];

    logic             valid_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;

`ifdef PIPE_ADDSUB_OVF_EN
    logic             lastMsbCarry_d;
    logic             msbCarry_q;
`endif

    assign bEff = b ^ {WIDTH{sub}};
    assign cEff = cin ^ sub;

    for (genvar k = 0; k < NSTAGES; k++) begin : g_stage
        localparam int LO = k * DIGIT;
        localparam int BW = WIDTH - LO;
        localparam int SW = (BW < DIGIT) ? BW : DIGIT;

        logic [WIDTH-1:0] aIn;
        logic [BW-1:0]    bIn;
        logic             cIn;
        logic             vIn;
        logic [SW:0]      slice;
        logic [WIDTH-1:0] sumWord;

        // Stage 0 adds straight from the ports so the result lands after NSTAGES register ranks.
        if (k == 0) begin : g_head
            assign aIn = a;
            assign bIn = bEff;
            assign cIn = cEff;
            assign vIn = in_valid;
        end else begin : g_body
            logic [WIDTH-1:0] aStage_q;
            logic [BW-1:0]    bStage_q;
            logic             cStage_q;
            logic             vStage_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    aStage_q <= '0;
                    bStage_q <= '0;
                    cStage_q <= 1'b0;
                    vStage_q <= 1'b0;
                end else if (ce) begin
                    aStage_q <= stageSum_d[k-1];
                    bStage_q <= g_stage[k-1].bIn[BW+DIGIT-1:DIGIT];
                    cStage_q <= stageCarry_d[k-1];
                    vStage_q <= stageValid_d[k-1];
                end
            end

            assign aIn = aStage_q;
            assign bIn = bStage_q;
            assign cIn = cStage_q;
            assign vIn = vStage_q;
        end

        assign slice = {1'b0, aIn[LO +: SW]} + {1'b0, bIn[SW-1:0]} + {{SW{1'b0}}, cIn};

        always_comb begin
            sumWord = aIn;
            sumWord[LO +: SW] = slice[SW-1:0];
        end

        assign stageSum_d[k]   = sumWord;
        assign stageCarry_d[k] = slice[SW];
        assign stageValid_d[k] = vIn;

`ifdef PIPE_ADDSUB_OVF_EN
        // Carry into the MSB recovered from the MSB's own sum bit and operands.
        if (k == NSTAGES - 1) begin : g_msb
            assign lastMsbCarry_d = aIn[WIDTH-1] ^ bIn[SW-1] ^ slice[SW-1];
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else if (ce) begin
            valid_q <= stageValid_d[NSTAGES-1];
            sum_q   <= stageSum_d[NSTAGES-1];
            carry_q <= stageCarry_d[NSTAGES-1];
        end
    end

`ifdef PIPE_ADDSUB_OVF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            msbCarry_q <= 1'b0;
        end else if (ce) begin
            msbCarry_q <= lastMsbCarry_d;
        end
    end

    assign ovf = msbCarry_q ^ carry_q;
`else
    assign ovf = 1'b0;
`endif

    assign out_valid = valid_q;
    assign s         = sum_q;
    assign c         = carry_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub: directed vectors, stall and reset sequences, random traffic
// on a 16/4 build and a 10/4 build, all compared against an arithmetic reference model.
module tb_pipelined_addsub;
    localparam int WA = 16;
    localparam int DA = 4;
    localparam int NA = 4;
    localparam int WB = 10;
    localparam int DB = 4;
    localparam int NB = 3;

`ifdef PIPE_ADDSUB_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] s;
        logic        c;
        logic        ovf;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          ce;
    logic          vInA, cinA, subA;
    logic [WA-1:0] aInA, bInA;
    logic          outValidA, cA, ovfA;
    logic [WA-1:0] sA;
    logic          vInB, cinB, subB;
    logic [WB-1:0] aInB, bInB;
    logic          outValidB, cB, ovfB;
    logic [WB-1:0] sB;

    int checks = 0;
    int errors = 0;
    bit monEn  = 1'b0;

    logic [18:0] pipeA [$];
    logic [18:0] pipeB [$];
    logic [18:0] mdlOutA;
    logic [18:0] mdlOutB;

    always #5 clk = ~clk;

    pipelined_addsub #(.WIDTH(WA), .DIGIT(DA)) dutA (
        .clk(clk), .rst(rst), .ce(ce), .in_valid(vInA), .a(aInA), .b(bInA),
        .cin(cinA), .sub(subA), .out_valid(outValidA), .s(sA), .c(cA), .ovf(ovfA)
    );

    pipelined_addsub #(.WIDTH(WB), .DIGIT(DB)) dutB (
        .clk(clk), .rst(rst), .ce(ce), .in_valid(vInB), .a(aInB), .b(bInB),
        .cin(cinB), .sub(subB), .out_valid(outValidB), .s(sB), .c(cB), .ovf(ovfB)
    );

    // Plain integer arithmetic: returns {ovf, c, s} for a w-bit add or subtract.
    function automatic logic [17:0] refModel(input int w, input logic [15:0] x,
                                             input logic [15:0] y, input logic ci,
                                             input logic sb);
        longint modv, half, ux, uy, sx, sy, r, sr;
        logic [15:0] sv;
        logic cv, ov;
        modv = longint'(1) << w;
        half = modv / 2;
        ux = longint'(x);
        uy = longint'(y);
        sx = (ux >= half) ? ux - modv : ux;
        sy = (uy >= half) ? uy - modv : uy;
        if (sb) begin
            r  = ux - uy - longint'(ci);
            sr = sx - sy - longint'(ci);
            cv = (r >= 0);
        end else begin
            r  = ux + uy + longint'(ci);
            sr = sx + sy + longint'(ci);
            cv = (r >= modv);
        end
        sv = 16'(r & (modv - 1));
        ov = OVF_EN && ((sr >= half) || (sr < -half));
        return {ov, cv, sv};
    endfunction

    // Latency model: each build is a delay line of NSTAGES enabled edges.
    always @(posedge clk) begin
        if (rst) begin
            pipeA.delete();
            pipeB.delete();
            for (int i = 0; i < NA - 1; i++) pipeA.push_back('0);
            for (int i = 0; i < NB - 1; i++) pipeB.push_back('0);
            mdlOutA = '0;
            mdlOutB = '0;
        end else if (ce) begin
            pipeA.push_front({vInA, refModel(WA, aInA, bInA, cinA, subA)});
            mdlOutA = pipeA.pop_back();
            pipeB.push_front({vInB, refModel(WB, 16'(aInB), 16'(bInB), cinB, subB)});
            mdlOutB = pipeB.pop_back();
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (monEn) begin
            checkOutput("monA_valid", 32'(outValidA), 32'(mdlOutA[18]));
            if (mdlOutA[18]) checkOutput("monA_result", 32'({ovfA, cA, sA}), 32'(mdlOutA[17:0]));
            checkOutput("monB_valid", 32'(outValidB), 32'(mdlOutB[18]));
            if (mdlOutB[18]) checkOutput("monB_result", 32'({ovfB, cB, 6'b0, sB}), 32'(mdlOutB[17:0]));
        end
    end

    task automatic applyStimulus(input logic [15:0] x, input logic [15:0] y,
                                 input logic ci, input logic sb, input logic v);
        aInA = x;
        bInA = y;
        cinA = ci;
        subA = sb;
        vInA = v;
        @(negedge clk);
    endtask

    task automatic runVector(input int idx, input vec_t v);
        int lat;
        applyStimulus(v.a, v.b, v.cin, v.sub, 1'b1);
        vInA = 1'b0;
        lat = 1;
        while (!outValidA && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        checkOutput($sformatf("vec%0d_latency", idx), 32'(lat), 32'(NA));
        checkOutput($sformatf("vec%0d_s", idx), 32'(sA), 32'(v.s));
        checkOutput($sformatf("vec%0d_c", idx), 32'(cA), 32'(v.c));
        checkOutput($sformatf("vec%0d_ovf", idx), 32'(ovfA), 32'(v.ovf & OVF_EN));
        @(negedge clk);
        checkOutput($sformatf("vec%0d_pulse", idx), 32'(outValidA), 32'd0);
    endtask

    initial begin
        vec_t vecs [10];
        int cyc, seen, firstT;
        int firstA, lastA, cntA, firstB, lastB, cntB;
        logic [17:0] got;

        vecs[0] = '{16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[5] = '{16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000E, 1'b1, 1'b0};
        vecs[6] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[7] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        vecs[8] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[9] = '{16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0};

        rst = 1'b1;
        ce = 1'b1;
        aInA = '0; bInA = '0; cinA = 1'b0; subA = 1'b0; vInA = 1'b0;
        aInB = '0; bInB = '0; cinB = 1'b0; subB = 1'b0; vInB = 1'b0;
        @(negedge clk);
        checkOutput("reset_validA", 32'(outValidA), 32'd0);
        checkOutput("reset_resultA", 32'({ovfA, cA, sA}), 32'd0);
        checkOutput("reset_validB", 32'(outValidB), 32'd0);
        rst = 1'b0;
        monEn = 1'b1;

        for (int i = 0; i < 10; i++) runVector(i, vecs[i]);

        // Two operations in flight, then three disabled edges with junk on the inputs.
        applyStimulus(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b1);
        applyStimulus(16'hF000, 16'h1000, 1'b1, 1'b1, 1'b1);
        ce = 1'b0;
        applyStimulus(16'hDEAD, 16'hBEEF, 1'b1, 1'b0, 1'b1);
        applyStimulus(16'h4321, 16'h1234, 1'b0, 1'b1, 1'b1);
        applyStimulus(16'hAAAA, 16'h5555, 1'b1, 1'b1, 1'b1);
        ce = 1'b1;
        vInA = 1'b0;
        cyc = 5;
        while (!outValidA && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("stall_arrival", 32'(cyc), 32'd7);
        checkOutput("stall_op0", 32'({ovfA, cA, sA}), 32'({1'b0, 1'b0, 16'h3333}));
        @(negedge clk);
        checkOutput("stall_op1_valid", 32'(outValidA), 32'd1);
        checkOutput("stall_op1", 32'({ovfA, cA, sA}), 32'({1'b0, 1'b1, 16'hDFFF}));
        @(negedge clk);
        checkOutput("stall_no_dup", 32'(outValidA), 32'd0);

        // A finished result must sit unchanged on the outputs while ce is low.
        applyStimulus(16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b1);
        vInA = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("hold_arrive", 32'(outValidA), 32'd1);
        ce = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput($sformatf("hold_valid%0d", i), 32'(outValidA), 32'd1);
            checkOutput($sformatf("hold_s%0d", i), 32'(sA), 32'h0100);
        end
        ce = 1'b1;
        @(negedge clk);
        checkOutput("hold_release", 32'(outValidA), 32'd0);

        // Reset with three operations in flight; reset wins even with ce low.
        applyStimulus(16'h1000, 16'h0001, 1'b0, 1'b0, 1'b1);
        applyStimulus(16'h2000, 16'h0002, 1'b0, 1'b1, 1'b1);
        applyStimulus(16'h3000, 16'h0003, 1'b1, 1'b0, 1'b1);
        rst = 1'b1;
        ce = 1'b0;
        applyStimulus(16'h7777, 16'h1111, 1'b0, 1'b0, 1'b1);
        checkOutput("rst_valid", 32'(outValidA), 32'd0);
        checkOutput("rst_result", 32'({ovfA, cA, sA}), 32'd0);
        rst = 1'b0;
        ce = 1'b1;
        applyStimulus(16'h0ABC, 16'h0123, 1'b0, 1'b0, 1'b1);
        vInA = 1'b0;
        seen = 0;
        firstT = -1;
        got = '0;
        for (int t = 5; t <= 12; t++) begin
            if (outValidA) begin
                seen++;
                if (firstT < 0) begin
                    firstT = t;
                    got = {ovfA, cA, sA};
                end
            end
            @(negedge clk);
        end
        checkOutput("rst_new_arrival", 32'(firstT), 32'd8);
        checkOutput("rst_only_one", 32'(seen), 32'd1);
        checkOutput("rst_new_result", 32'(got), 32'({1'b0, 1'b0, 16'h0BDF}));

        // Back-to-back random traffic on both builds.
        firstA = -1; lastA = -1; cntA = 0;
        firstB = -1; lastB = -1; cntB = 0;
        for (int t = 0; t < 210; t++) begin
            if (t < 200) begin
                aInB = 10'($urandom);
                bInB = 10'($urandom);
                cinB = 1'($urandom);
                subB = 1'($urandom);
                vInB = 1'b1;
                applyStimulus(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b1);
            end else begin
                vInB = 1'b0;
                applyStimulus(16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
            end
            if (outValidA) begin
                if (firstA < 0) firstA = t + 1;
                lastA = t + 1;
                cntA++;
            end
            if (outValidB) begin
                if (firstB < 0) firstB = t + 1;
                lastB = t + 1;
                cntB++;
            end
        end
        checkOutput("randA_first", 32'(firstA), 32'd4);
        checkOutput("randA_count", 32'(cntA), 32'd200);
        checkOutput("randA_run", 32'(lastA - firstA + 1), 32'd200);
        checkOutput("randB_first", 32'(firstB), 32'd3);
        checkOutput("randB_count", 32'(cntB), 32'd200);
        checkOutput("randB_run", 32'(lastB - firstB + 1), 32'd200);

        monEn = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
